// File: rtl/sm_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory slave between N req/ack masters.
// Define SM_MEM_ARBITER_BACK2BACK_EN to chain grants on the ack cycle with no idle bubble.
module sm_mem_arbiter #(
    parameter int unsigned N          = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N-1:0]            m_req,
    input  logic [N-1:0]            m_we,
    input  logic [N*ADDR_WIDTH-1:0] m_addr,
    input  logic [N*DATA_WIDTH-1:0] m_wdata,
    output logic [N-1:0]            m_ack,
    output logic [DATA_WIDTH-1:0]   m_rdata,
    output logic                    s_req,
    output logic                    s_we,
    output logic [ADDR_WIDTH-1:0]   s_addr,
    output logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic                    s_ack,
    input  logic [DATA_WIDTH-1:0]   s_rdata
);

    localparam int unsigned PW = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [PW-1:0]   ptr_q,   ptr_d;
    logic [PW-1:0]   g;
    logic [PW-1:0]   ptr_nxt;
    logic            req_g;

    // First set bit of req, searching upward from start and wrapping at N-1.
    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] req, input logic [PW-1:0] start);
        logic [N-1:0] sel;
        logic         found;
        int unsigned  idx;
        sel   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(start) + k) % N;
            if (!found && req[idx]) begin
                sel[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return sel;
    endfunction

    always_comb begin
        g = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_q[i]) g = PW'(i);
        end
    end

    assign ptr_nxt = (g == PW'(N - 1)) ? '0 : g + 1'b1;

    always_comb begin
        s_we    = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        req_g   = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                s_we    = m_we[i];
                s_addr  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_wdata = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                req_g   = m_req[i];
            end
        end
    end

    assign m_rdata = s_rdata;

`ifdef SM_MEM_ARBITER_BACK2BACK_EN
    logic [N-1:0] b2b_req;
    logic [N-1:0] b2b_grant;
    // Next grant is chosen from the post-ack pointer, excluding the master being acked.
    assign b2b_req   = m_req & ~grant_q;
    assign b2b_grant = rr_pick(b2b_req, ptr_nxt);
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        s_req   = 1'b0;
        m_ack   = '0;
        case (state_q)
            IDLE: begin
                if (|m_req) begin
                    grant_d = rr_pick(m_req, ptr_q);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!req_g) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else begin
                    s_req = 1'b1;
                    if (s_ack) begin
                        m_ack = grant_q;
                        ptr_d = ptr_nxt;
`ifdef SM_MEM_ARBITER_BACK2BACK_EN
                        if (|b2b_req) begin
                            grant_d = b2b_grant;
                        end else begin
                            state_d = IDLE;
                            grant_d = '0;
                        end
`else
                        state_d = IDLE;
                        grant_d = '0;
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_sm_mem_arbiter.sv
// Scoreboard bench for sm_mem_arbiter (N=2): master drivers, latency-programmable slave, ack monitor.
module tb_sm_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
`ifdef SM_MEM_ARBITER_BACK2BACK_EN
    localparam logic B2B = 1'b1;
`else
    localparam logic B2B = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    m_req, m_we, m_ack;
    logic [2*AW-1:0] m_addr;
    logic [2*DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          s_req, s_we, s_ack;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;

    always #5 clk = ~clk;

    sm_mem_arbiter #(.N(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_rdata(s_rdata)
    );

    typedef struct {
        int unsigned mst;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int unsigned abort_after;
    } txn_t;

    txn_t        mq0[$];
    txn_t        mq1[$];
    txn_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned slat;
    logic        spur;
    logic [1:0]  ackd;
    int unsigned abort_n[2];
    int unsigned age[2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return a ^ 32'h0000_CAEE;
    endfunction

    task automatic send(input int unsigned m, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input int unsigned abort_after);
        txn_t t;
        t.mst = m; t.we = we; t.addr = a; t.wdata = wd; t.rdata = '0; t.abort_after = abort_after;
        if (m == 0) mq0.push_back(t); else mq1.push_back(t);
    endtask

    task automatic expect_txn(input int unsigned m, input logic we, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd);
        txn_t t;
        t.mst = m; t.we = we; t.addr = a; t.wdata = wd; t.rdata = rd; t.abort_after = 0;
        sb.push_back(t);
    endtask

    task automatic wait_drain(input string tag, input int unsigned budget);
        int unsigned c = 0;
        while ((mq0.size() + mq1.size() + sb.size() != 0 || m_req != 2'b00) && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, 64'(c < budget), 64'd1);
    endtask

    task automatic wait_sreq(input string tag, input int unsigned budget);
        int unsigned c = 0;
        while (!s_req && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, 64'(s_req), 64'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_sreq", 64'(s_req), 64'd0);
        check("rst_mack", 64'(m_ack), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load(input int unsigned i, input txn_t t);
        m_we[i]              = t.we;
        m_addr[i*AW +: AW]   = t.addr;
        m_wdata[i*DW +: DW]  = t.wdata;
        abort_n[i]           = t.abort_after;
        age[i]               = 0;
        m_req[i]             = 1'b1;
    endtask

    initial begin
        txn_t        e;
        int unsigned c;
        rst_n = 1'b0; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
        s_ack = 1'b0; s_rdata = '0; slat = 2; spur = 1'b0; ackd = '0;
        abort_n[0] = 0; abort_n[1] = 0; age[0] = 0; age[1] = 0;

        fork
            // Master drivers: hold each request until acked (or until its abort age).
            forever begin
                txn_t t;
                @(posedge clk); #1;
                for (int i = 0; i < 2; i++) begin
                    if (m_req[i]) begin
                        if (ackd[i]) m_req[i] = 1'b0;
                        else if (abort_n[i] != 0) begin
                            age[i]++;
                            if (age[i] >= abort_n[i]) m_req[i] = 1'b0;
                        end
                    end
                end
                ackd = '0;
                if (!m_req[0] && mq0.size() > 0) begin t = mq0.pop_front(); load(0, t); end
                if (!m_req[1] && mq1.size() > 0) begin t = mq1.pop_front(); load(1, t); end
            end
            // Slave: ack after slat cycles of s_req; spur forces one unsolicited ack.
            begin
                int unsigned cnt = 0;
                forever begin
                    @(posedge clk); #2;
                    if (!rst_n) begin
                        s_ack = 1'b0; cnt = 0;
                    end else if (spur) begin
                        s_ack = 1'b1; s_rdata = 32'hDEAD_BEEF; spur = 1'b0;
                    end else if (s_ack) begin
                        s_ack = 1'b0; cnt = 0;
                    end else if (s_req) begin
                        if (cnt >= slat) begin
                            s_ack = 1'b1; s_rdata = slave_data(s_addr);
                        end else cnt++;
                    end else cnt = 0;
                end
            end
            forever begin
                @(negedge clk);
                ackd = m_ack;
                if (rst_n && m_ack != 2'b00) begin
                    if (sb.size() == 0) check("ack_unexpected", 64'(m_ack), 64'd0);
                    else begin
                        e = sb.pop_front();
                        check("ack_master", 64'(m_ack), 64'd1 << e.mst);
                        check("ack_addr", 64'(s_addr), 64'(e.addr));
                        check("ack_we", 64'(s_we), 64'(e.we));
                        if (e.we) check("ack_wdata", 64'(s_wdata), 64'(e.wdata));
                        else      check("ack_rdata", 64'(m_rdata), 64'(e.rdata));
                    end
                end
            end
            begin
                #2_000_000;
                $display("FAIL watchdog: simulation did not finish");
                $fatal(1);
            end
        join_none

        do_reset();

        // Single read, first-request latency.
        @(negedge clk);
        expect_txn(0, 1'b0, 32'h10, 32'h0, 32'h0000_CAFE);
        send(0, 1'b0, 32'h10, 32'h0, 0);
        @(negedge clk);
        check("t1_sreq_c0", 64'(s_req), 64'd0);
        @(negedge clk);
        check("t1_sreq_c1", 64'(s_req), 64'd1);
        wait_drain("t1_drain", 50);

        // ptr is now 1: simultaneous requests go to master 1 first.
        expect_txn(1, 1'b0, 32'h14, 32'h0, slave_data(32'h14));
        expect_txn(0, 1'b0, 32'h18, 32'h0, slave_data(32'h18));
        send(0, 1'b0, 32'h18, 32'h0, 0);
        send(1, 1'b0, 32'h14, 32'h0, 0);
        wait_drain("t1b_drain", 50);

        // Both request at reset exit: master 0 then 1, bubble depends on build.
        do_reset();
        expect_txn(0, 1'b0, 32'h40, 32'h0, slave_data(32'h40));
        expect_txn(1, 1'b0, 32'h44, 32'h0, slave_data(32'h44));
        send(0, 1'b0, 32'h40, 32'h0, 0);
        send(1, 1'b0, 32'h44, 32'h0, 0);
        c = 0;
        do begin @(negedge clk); c++; end while (!m_ack[0] && c < 50);
        check("t2_ack0_seen", 64'(m_ack[0]), 64'd1);
        @(negedge clk);
        check("t2_b2b_sreq", 64'(s_req), 64'(B2B));
        wait_drain("t2_drain", 50);

        // Continuous master 0, one-shot master 1: order 0,1,0,0.
        expect_txn(0, 1'b0, 32'h100, 32'h0, slave_data(32'h100));
        expect_txn(1, 1'b0, 32'h200, 32'h0, slave_data(32'h200));
        expect_txn(0, 1'b0, 32'h104, 32'h0, slave_data(32'h104));
        expect_txn(0, 1'b0, 32'h108, 32'h0, slave_data(32'h108));
        send(0, 1'b0, 32'h100, 32'h0, 0);
        send(0, 1'b0, 32'h104, 32'h0, 0);
        send(0, 1'b0, 32'h108, 32'h0, 0);
        send(1, 1'b0, 32'h200, 32'h0, 0);
        wait_drain("t3_drain", 100);

        // Master 1 write while master 0 idle.
        expect_txn(1, 1'b1, 32'h20, 32'h1234, 32'h0);
        send(1, 1'b1, 32'h20, 32'h1234, 0);
        wait_sreq("t4_sreq", 20);
        check("t4_swe", 64'(s_we), 64'd1);
        check("t4_saddr", 64'(s_addr), 64'h20);
        check("t4_swdata", 64'(s_wdata), 64'h1234);
        wait_drain("t4_drain", 50);

        // Leave ptr at 1, then reset mid-transaction of master 1.
        expect_txn(0, 1'b0, 32'h30, 32'h0, slave_data(32'h30));
        send(0, 1'b0, 32'h30, 32'h0, 0);
        wait_drain("t5_pre_drain", 50);
        slat = 3;
        send(1, 1'b0, 32'h50, 32'h0, 0);
        wait_sreq("t5_sreq", 20);
        send(0, 1'b0, 32'h60, 32'h0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_sreq", 64'(s_req), 64'd0);
        check("t5_rst_mack", 64'(m_ack), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_txn(0, 1'b0, 32'h60, 32'h0, slave_data(32'h60));
        expect_txn(1, 1'b0, 32'h50, 32'h0, slave_data(32'h50));
        wait_drain("t5_drain", 80);

        // Granted master drops its request before the slave acks.
        slat = 5;
        send(0, 1'b0, 32'h70, 32'h0, 2);
        wait_sreq("t6_sreq", 20);
        c = 0;
        while (m_req[0] && c < 20) begin @(negedge clk); c++; end
        check("t6_dropped", 64'(m_req[0]), 64'd0);
        check("t6_sreq_drop", 64'(s_req), 64'd0);
        spur = 1'b1;
        @(negedge clk);
        check("t6_spur_mack", 64'(m_ack), 64'd0);
        check("t6_spur_sreq", 64'(s_req), 64'd0);
        @(negedge clk);
        slat = 2;
        // ptr must still be 0 after the abort.
        expect_txn(0, 1'b0, 32'h90, 32'h0, slave_data(32'h90));
        expect_txn(1, 1'b0, 32'h94, 32'h0, slave_data(32'h94));
        send(0, 1'b0, 32'h90, 32'h0, 0);
        send(1, 1'b0, 32'h94, 32'h0, 0);
        wait_drain("t6_drain", 80);

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
